// File: rtl/instr_decode_stage.sv
//------------------------------------------------------------------------------
// Module   : instr_decode_stage
// Brief    : Registered LEGv8 decode stage with a 2-entry skid buffer. Splits
//            the instruction into fields, classifies the format and extends
//            the immediate. Valid/ready on both sides, registered in_ready.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module instr_decode_stage #(
  parameter int INSTR_LEN = 32,
  parameter int WORD      = 64,
  parameter int REG_BITS  = 5,
  parameter int CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [INSTR_LEN-1:0] instruction,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [10:0]          opcode,
  output logic [2:0]           fmt,
  output logic [REG_BITS-1:0]  rm_num,
  output logic [REG_BITS-1:0]  rn_num,
  output logic [REG_BITS-1:0]  rd_num,
  output logic [5:0]           shamt,
  output logic [WORD-1:0]      imm,
  output logic [CNT_W-1:0]     decoded_count
);

  localparam logic [2:0] c_FMT_R  = 3'd0;
  localparam logic [2:0] c_FMT_I  = 3'd1;
  localparam logic [2:0] c_FMT_D  = 3'd2;
  localparam logic [2:0] c_FMT_B  = 3'd3;
  localparam logic [2:0] c_FMT_CB = 3'd4;
  localparam logic [2:0] c_FMT_IW = 3'd5;
  localparam logic [2:0] c_FMT_IL = 3'd7;

  // Bundle layout (MSB first): opcode, fmt, rm, rn, rd, shamt, imm
  localparam int c_BW = 11 + 3 + 3 * REG_BITS + 6 + WORD;
  localparam logic [CNT_W-1:0] c_CNT_ONE = 1;

  logic [2:0]       w_fmt;
  logic [5:0]       w_shamt;
  logic [WORD-1:0]  w_imm;
  logic [10:0]      w_op;
  logic [c_BW-1:0]  w_in_bundle;
  logic             w_accept;
  logic             w_emit;

  logic [c_BW-1:0]  r_main;
  logic [c_BW-1:0]  r_skid;
  logic             r_main_valid;
  logic             r_skid_valid;
  logic [CNT_W-1:0] r_count;

  assign w_op = instruction[31:21];

  // Format classification and immediate extension; earlier matches take priority
  always_comb begin
    w_fmt   = c_FMT_IL;
    w_imm   = '0;
    w_shamt = '0;
    if (instruction[31:26] == 6'b000101 || instruction[31:26] == 6'b100101) begin
      w_fmt = c_FMT_B;
      w_imm = {{(WORD-26){instruction[25]}}, instruction[25:0]};
    end else if (instruction[31:24] == 8'b10110100 || instruction[31:24] == 8'b10110101 ||
                 instruction[31:24] == 8'b01010100) begin
      w_fmt = c_FMT_CB;
      w_imm = {{(WORD-19){instruction[23]}}, instruction[23:5]};
    end else if (instruction[31:23] == 9'b110100101 || instruction[31:23] == 9'b111100101) begin
      w_fmt   = c_FMT_IW;
      w_imm   = {{(WORD-16){1'b0}}, instruction[20:5]};
      w_shamt = {instruction[22:21], 4'b0000};
    end else if (instruction[31:22] == 10'b1001000100 || instruction[31:22] == 10'b1011000100 ||
                 instruction[31:22] == 10'b1101000100 || instruction[31:22] == 10'b1111000100 ||
                 instruction[31:22] == 10'b1001001000 || instruction[31:22] == 10'b1011001000 ||
                 instruction[31:22] == 10'b1101001000) begin
      w_fmt = c_FMT_I;
      w_imm = {{(WORD-12){1'b0}}, instruction[21:10]};
    end else if (w_op == 11'b11111000010 || w_op == 11'b11111000000 ||
                 w_op == 11'b10111000100) begin
      w_fmt = c_FMT_D;
      w_imm = {{(WORD-9){instruction[20]}}, instruction[20:12]};
    end else if (w_op == 11'b10001011000 || w_op == 11'b11001011000 ||
                 w_op == 11'b10001010000 || w_op == 11'b10101010000 ||
                 w_op == 11'b11001010000 || w_op == 11'b11010011011 ||
                 w_op == 11'b11010011010 || w_op == 11'b11010110000) begin
      w_fmt   = c_FMT_R;
      w_shamt = instruction[15:10];
    end
  end

  assign w_in_bundle = {w_op, w_fmt, instruction[20:16], instruction[9:5],
                        instruction[4:0], w_shamt, w_imm};

  // in_ready is a pure function of a flop, so it carries no combinational path
  assign in_ready = ~r_skid_valid;
  assign w_accept = in_valid & ~r_skid_valid & ~flush;
  assign w_emit   = r_main_valid & out_ready;

  // Main/skid storage: main feeds the outputs, skid absorbs one extra word
  // while the consumer stalls; flush empties both but an emit still counts
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_main       <= '0;
      r_skid       <= '0;
      r_main_valid <= 1'b0;
      r_skid_valid <= 1'b0;
      r_count      <= '0;
    end else begin
      if (w_emit) begin
        r_count <= r_count + c_CNT_ONE;
      end
      if (flush) begin
        r_main_valid <= 1'b0;
        r_skid_valid <= 1'b0;
      end else if (w_emit || !r_main_valid) begin
        if (r_skid_valid) begin
          r_main       <= r_skid;
          r_main_valid <= 1'b1;
          r_skid_valid <= 1'b0;
        end else begin
          r_main_valid <= w_accept;
          if (w_accept) begin
            r_main <= w_in_bundle;
          end
        end
      end else if (w_accept) begin
        r_skid       <= w_in_bundle;
        r_skid_valid <= 1'b1;
      end
    end
  end

  assign out_valid     = r_main_valid;
  assign decoded_count = r_count;
  assign {opcode, fmt, rm_num, rn_num, rd_num, shamt, imm} = r_main;

endmodule

`default_nettype wire

// File: tb/tb_instr_decode_stage.sv
//------------------------------------------------------------------------------
// Module   : tb_instr_decode_stage
// Brief    : Self-checking bench for instr_decode_stage; scoreboard of expected
//            decoded bundles with occupancy model for in_ready/out_valid.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_instr_decode_stage;

  typedef struct packed {
    logic [10:0] opcode;
    logic [2:0]  fmt;
    logic [4:0]  rm;
    logic [4:0]  rn;
    logic [4:0]  rd;
    logic [5:0]  shamt;
    logic [63:0] imm;
  } bundle_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] instruction = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [10:0] opcode;
  logic [2:0]  fmt;
  logic [4:0]  rm_num, rn_num, rd_num;
  logic [5:0]  shamt;
  logic [63:0] imm;
  logic [3:0]  decoded_count;

  int          checks = 0;
  int          errors = 0;
  bundle_t     q[$];
  logic [3:0]  exp_count = '0;

  instr_decode_stage #(.INSTR_LEN(32), .WORD(64), .REG_BITS(5), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .instruction(instruction), .out_valid(out_valid), .out_ready(out_ready),
    .opcode(opcode), .fmt(fmt), .rm_num(rm_num), .rn_num(rn_num), .rd_num(rd_num),
    .shamt(shamt), .imm(imm), .decoded_count(decoded_count)
  );

  always #5 clk = ~clk;

  // Reference decoder written as a wildcard table on the top 11 bits
  function automatic bundle_t ref_decode(input logic [31:0] w);
    bundle_t b;
    b.opcode = w[31:21];
    b.rm     = w[20:16];
    b.rn     = w[9:5];
    b.rd     = w[4:0];
    b.fmt    = 3'd7;
    b.shamt  = 6'd0;
    b.imm    = 64'd0;
    casez (w[31:21])
      11'b000101?????, 11'b100101?????: begin
        b.fmt = 3'd3; b.imm = 64'(signed'(w[25:0]));
      end
      11'b10110100???, 11'b10110101???, 11'b01010100???: begin
        b.fmt = 3'd4; b.imm = 64'(signed'(w[23:5]));
      end
      11'b110100101??, 11'b111100101??: begin
        b.fmt = 3'd5; b.imm = 64'(w[20:5]); b.shamt = 6'(w[22:21] * 16);
      end
      11'b1001000100?, 11'b1011000100?, 11'b1101000100?, 11'b1111000100?,
      11'b1001001000?, 11'b1011001000?, 11'b1101001000?: begin
        b.fmt = 3'd1; b.imm = 64'(w[21:10]);
      end
      11'b11111000010, 11'b11111000000, 11'b10111000100: begin
        b.fmt = 3'd2; b.imm = 64'(signed'(w[20:12]));
      end
      11'b10001011000, 11'b11001011000, 11'b10001010000, 11'b10101010000,
      11'b11001010000, 11'b11010011011, 11'b11010011010, 11'b11010110000: begin
        b.fmt = 3'd0; b.shamt = w[15:10];
      end
      default: ;
    endcase
    return b;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: check outputs against the model at the falling edge, update
  // the scoreboard with the handshakes of this cycle, then step past the edge
  task automatic tick();
    bundle_t f;
    bit      emit;
    bit      acc;
    @(negedge clk);
    check("out_valid", 64'(out_valid), 64'(q.size() > 0));
    check("in_ready", 64'(in_ready), 64'(q.size() < 2));
    check("count", 64'(decoded_count), 64'(exp_count));
    if (q.size() > 0) begin
      f = q[0];
      check("opcode", 64'(opcode), 64'(f.opcode));
      check("fmt", 64'(fmt), 64'(f.fmt));
      check("rm", 64'(rm_num), 64'(f.rm));
      check("rn", 64'(rn_num), 64'(f.rn));
      check("rd", 64'(rd_num), 64'(f.rd));
      check("shamt", 64'(shamt), 64'(f.shamt));
      check("imm", imm, f.imm);
    end
    emit = (q.size() > 0) && out_ready;
    acc  = in_valid && (q.size() < 2) && !flush;
    if (emit) begin
      void'(q.pop_front());
      exp_count++;
    end
    if (flush) q.delete();
    if (acc) q.push_back(ref_decode(instruction));
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] w, input logic rdy, input logic fl);
    in_valid    = v;
    instruction = w;
    out_ready   = rdy;
    flush       = fl;
  endtask

  task automatic drain();
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    for (int i = 0; i < 8 && q.size() > 0; i++) tick();
    check("drain_timeout", 64'(q.size()), 64'd0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    q.delete();
    exp_count = '0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  logic [31:0] stream [8] = '{32'h91001441, 32'hF85F8083, 32'h17FFFFFF, 32'hB4000089,
                              32'h8B020020, 32'hF2A00041, 32'h00000000, 32'hD3608C41};

  initial begin
    // Reset state
    rst_n = 1'b0;
    #12;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_count", 64'(decoded_count), 64'd0);
    check("rst_fmt", 64'(fmt), 64'd0);
    check("rst_imm", imm, 64'd0);
    check("rst_opcode", 64'(opcode), 64'd0);
    do_reset();

    // ADDI X1,X2,#5 with 1-cycle latency
    drive(1'b1, 32'h91001441, 1'b1, 1'b0);
    tick();
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    check("addi_valid", 64'(out_valid), 64'd1);
    check("addi_fmt", 64'(fmt), 64'd1);
    check("addi_rd", 64'(rd_num), 64'd1);
    check("addi_rn", 64'(rn_num), 64'd2);
    check("addi_imm", imm, 64'd5);
    tick();

    // LDUR X3,[X4,#-8]
    drive(1'b1, 32'hF85F8083, 1'b1, 1'b0);
    tick();
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    check("ldur_fmt", 64'(fmt), 64'd2);
    check("ldur_imm", imm, 64'hFFFF_FFFF_FFFF_FFF8);
    check("ldur_rd", 64'(rd_num), 64'd3);
    check("ldur_rn", 64'(rn_num), 64'd4);
    tick();

    // B #-1 then CBZ X9,#4 back to back
    drive(1'b1, 32'h17FFFFFF, 1'b1, 1'b0);
    tick();
    drive(1'b1, 32'hB4000089, 1'b1, 1'b0);
    check("b_fmt", 64'(fmt), 64'd3);
    check("b_imm", imm, 64'hFFFF_FFFF_FFFF_FFFF);
    tick();
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    check("cbz_fmt", 64'(fmt), 64'd4);
    check("cbz_imm", imm, 64'd4);
    check("cbz_rd", 64'(rd_num), 64'd9);
    tick();

    // Illegal word still passes through
    drive(1'b1, 32'h00000000, 1'b1, 1'b0);
    tick();
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    check("illegal_fmt", 64'(fmt), 64'd7);
    tick();

    // Stream of 8 with out_ready low for 3 cycles
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, stream[i], (i >= 3), 1'b0);
      tick();
      if (i == 2) check("stall_in_ready_low", 64'(in_ready), 64'd0);
      while (q.size() >= 2 && !out_ready) begin
        drive(1'b1, stream[i], 1'b1, 1'b0);
        tick();
      end
    end
    drain();

    // Fill skid, then flush with no emit
    drive(1'b1, 32'h8B020020, 1'b0, 1'b0); tick();
    drive(1'b1, 32'h91001441, 1'b0, 1'b0); tick();
    check("skid_full", 64'(in_ready), 64'd0);
    drive(1'b1, 32'hF85F8083, 1'b0, 1'b1); tick();
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    check("flush_out_valid", 64'(out_valid), 64'd0);
    check("flush_in_ready", 64'(in_ready), 64'd1);
    tick();

    // Flush while emitting: emit still counted
    drive(1'b1, 32'hB4000089, 1'b0, 1'b0); tick();
    drive(1'b1, 32'h17FFFFFF, 1'b0, 1'b0); tick();
    drive(1'b1, 32'h00000000, 1'b1, 1'b1); tick();
    drain();

    // Counter wrap with 4-bit counter: 17 emits -> 1
    do_reset();
    for (int i = 0; i < 17; i++) begin
      drive(1'b1, 32'h91000000 | 32'($urandom_range(0, 32'h3FFFFF)), 1'b1, 1'b0);
      tick();
    end
    drain();
    check("cnt_wrap", 64'(decoded_count), 64'd1);

    // Async reset mid-stall
    drive(1'b1, 32'hF85F8083, 1'b0, 1'b0); tick();
    drive(1'b1, 32'h8B020020, 1'b0, 1'b0); tick();
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    check("arst_out_valid", 64'(out_valid), 64'd0);
    check("arst_in_ready", 64'(in_ready), 64'd1);
    check("arst_count", 64'(decoded_count), 64'd0);
    q.delete();
    exp_count = '0;
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    drive(1'b1, 32'hF2A00041, 1'b1, 1'b0); tick();
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
